seg_scan_multi: RTL and testbench

SEG_SCAN_MULTI -- requirements
Module: seg_scan_multi

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 88 ++++++++
 rtl/seg_scan_multi.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_multi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
// Segment codes are active-low: bit7 = dp, bits6..0 = g..a.
// Also holds the converter state type and the width helper functions.
package seg_pkg;

  // Digit glyphs 0..9, index 0 in the least significant byte.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_e;

  // Bits needed to index n digits (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value max (at least one bit).
  function automatic int cnt_width(input int max);
    return (max <= 1) ? 1 : $clog2(max + 1);
  endfunction

  // BCD digits kept by the converter: enough for any DATA_W-bit value,
  // and never fewer than the display so overflow can be judged.
  function automatic int bcd_slots(input int data_w, input int digits);
    int need;
    need = (data_w * 30103) / 100000 + 1;
    return (need > digits) ? need : digits;
  endfunction

  // Glyph for one BCD digit; non-decimal nibbles render blank.
  function automatic logic [7:0] digit_code(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGITS[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// Latency: start accepted in IDLE/DONE, DATA_W SHIFT cycles, result valid during DONE.
// No backpressure: bcd is held until the next start is accepted.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6,
  localparam int NB = bcd_slots(DATA_W, DIGITS),
  localparam int BW = 4 * NB
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bcd
);

  localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  cv_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]     acc_adj;
  logic              load;

  // Converter state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= CV_IDLE;
    else         state_q <= state_d;
  end

  // Next state: DONE chains straight into a new conversion when start is held
  always_comb begin
    state_d = state_q;
    case (state_q)
      CV_IDLE:  if (start) state_d = CV_SHIFT;
      CV_SHIFT: if (bit_cnt_q == BCW'(DATA_W - 1)) state_d = CV_DONE;
      CV_DONE:  state_d = start ? CV_SHIFT : CV_IDLE;
      default:  state_d = CV_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy = (state_q == CV_SHIFT);
    done = (state_q == CV_DONE);
    bcd  = acc_q;
  end

  // Add 3 to every digit >= 5, then shift the next binary MSB in
  always_comb begin
    load    = start && (state_q != CV_SHIFT);
    acc_adj = acc_q;
    for (int i = 0; i < NB; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    sh_d      = sh_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      sh_d      = bin;
      acc_d     = '0;
      bit_cnt_d = '0;
    end else if (state_q == CV_SHIFT) begin
      sh_d      = sh_q << 1;
      acc_d     = {acc_adj[BW-2:0], sh_q[DATA_W-1]};
      bit_cnt_d = bit_cnt_q + BCW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_q      <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_multi.sv
// Multiplexed seven-segment driver: continuous BCD conversion, frame-locked display, blink, dp.
// Latency: sel/seg update one cycle after each scan tick; new values appear at the next frame boundary.
// No backpressure: data/point/sign are sampled whenever the converter restarts.
module seg_scan_multi
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int DATA_W       = 20,
  parameter int CNT_MAX      = 49_999,
  parameter int BLINK_FRAMES = 250
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] data,
  input  logic [DIGITS-1:0] point,
  input  logic              sign,
  input  logic              seg_en,
  input  logic [DIGITS-1:0] blink,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  localparam int IW = idx_width(DIGITS);
  localparam int CW = cnt_width(CNT_MAX);
  localparam int FW = cnt_width(BLINK_FRAMES - 1);
  localparam int NB = bcd_slots(DATA_W, DIGITS);

  // Scan timing
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_off_q, blink_off_d;
  logic          tick, frame_end;

  // Converter interface and captured attributes
  logic              cv_busy, cv_done;
  logic [4*NB-1:0]   cv_bcd;
  logic              sign_cap_q;
  logic [DIGITS-1:0] point_cap_q;

  // Last finished conversion, waiting for a frame boundary
  logic [4*NB-1:0]   res_bcd_q;
  logic              res_sign_q;
  logic [DIGITS-1:0] res_point_q;
  logic              res_vld_q;

  // Display register and outputs
  logic [7:0]        disp_q   [DIGITS];
  logic [7:0]        disp_d   [DIGITS];
  logic [7:0]        disp_new [DIGITS];
  logic [DIGITS-1:0] sel_q, sel_d;
  logic [7:0]        seg_q, seg_d;
  int                msd;
  logic              ovf;

  // Start is tied high so the converter runs back to back
  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (1'b1),
    .bin     (data),
    .busy    (cv_busy),
    .done    (cv_done),
    .bcd     (cv_bcd)
  );

  // Divider tick, digit index advance and blink phase bookkeeping
  always_comb begin
    tick        = (cnt_q == CW'(CNT_MAX));
    frame_end   = tick && (idx_q == IW'(DIGITS - 1));
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    blink_off_d = blink_off_q;
    if (tick) idx_d = frame_end ? '0 : idx_q + IW'(1);
    if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Scan timing registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      blink_off_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  // Sign/point follow the value: sampled as the converter takes data, kept with its result
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sign_cap_q  <= 1'b0;
      point_cap_q <= '0;
      res_bcd_q   <= '0;
      res_sign_q  <= 1'b0;
      res_point_q <= '0;
      res_vld_q   <= 1'b0;
    end else begin
      if (!cv_busy) begin
        sign_cap_q  <= sign;
        point_cap_q <= point;
      end
      if (cv_done) begin
        res_bcd_q   <= cv_bcd;
        res_sign_q  <= sign_cap_q;
        res_point_q <= point_cap_q;
        res_vld_q   <= 1'b1;
      end
    end
  end

  // Render the pending result: zero suppression, minus placement, overflow, dp
  always_comb begin
    msd = 0;
    for (int i = 0; i < NB; i++) begin
      if (res_bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    ovf = (msd + 1 + (res_sign_q ? 1 : 0)) > DIGITS;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf)                            disp_new[i] = SEG_MINUS;
      else if (i <= msd)                  disp_new[i] = digit_code(res_bcd_q[4*i +: 4]);
      else if (res_sign_q && i == msd + 1) disp_new[i] = SEG_MINUS;
      else                                disp_new[i] = SEG_BLANK;
      if (!ovf && res_point_q[i]) disp_new[i][7] = 1'b0;
    end
  end

  // Display only changes at a frame boundary so a frame never mixes two values
  always_comb begin
    disp_d = disp_q;
    if (frame_end && res_vld_q) disp_d = disp_new;
  end

  // Display register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) disp_q <= '{default: SEG_BLANK};
    else         disp_q <= disp_d;
  end

  // Output select: sel dark for the cycle after a tick, seg already shows the new digit
  always_comb begin
    sel_d = '0;
    if (seg_en && !tick) sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    if (!seg_en)                          seg_d = SEG_BLANK;
    else if (blink_off_d && blink[idx_d]) seg_d = SEG_BLANK;
    else                                  seg_d = disp_d[idx_d];
  end

  // Output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboard bench for seg_scan_multi (DIGITS=6, CNT_MAX=4, BLINK_FRAMES=2).
// Stimulus pushes expected digit slots / per-cycle probes; a monitor pops and compares.
// Frame sync waits are bounded; an expired bound is reported as a failure.
module tb_seg_scan_multi;

  localparam int DIGITS       = 6;
  localparam int DATA_W       = 20;
  localparam int CNT_MAX      = 4;
  localparam int BLINK_FRAMES = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic [DATA_W-1:0] data    = '0;
  logic [DIGITS-1:0] point   = '0;
  logic              sign    = 1'b0;
  logic              seg_en  = 1'b1;
  logic [DIGITS-1:0] blink   = '0;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] seg;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  probe_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string tname = "reset";

  seg_scan_multi #(
    .DIGITS       (DIGITS),
    .DATA_W       (DATA_W),
    .CNT_MAX      (CNT_MAX),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .blink   (blink),
    .sel     (sel),
    .seg     (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string kind, input obs_t e);
    n_cmp++;
    if (sel !== e.sel || seg !== e.seg) begin
      n_bad++;
      $display("FAIL %s/%s: got sel=%b seg=%h, expected sel=%b seg=%h",
               tname, kind, sel, seg, e.sel, e.seg);
    end
  endtask

  // Monitor: probes are checked on the next falling edge; digit slots whenever
  // a new non-zero select appears.
  initial begin : monitor
    obs_t       e;
    logic [5:0] prev_sel;
    prev_sel = '0;
    forever begin
      @(negedge sys_clk);
      if (probe_q.size() > 0) begin
        e = probe_q.pop_front();
        check("probe", e);
      end
      if (sel != '0 && sel != prev_sel && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("digit", e);
      end
      prev_sel = sel;
    end
  end

  // codes[i] is the expected glyph for digit i (digit 0 rightmost)
  task automatic push_frame(input logic [5:0][7:0] codes);
    obs_t o;
    for (int i = 0; i < DIGITS; i++) begin
      o.sel = 6'b000001 << i;
      o.seg = codes[i];
      exp_q.push_back(o);
    end
  endtask

  task automatic push_slot(input logic [5:0] s, input logic [7:0] c);
    obs_t o;
    o.sel = s;
    o.seg = c;
    exp_q.push_back(o);
  endtask

  task automatic push_probe(input logic [5:0] s, input logic [7:0] c);
    obs_t o;
    o.sel = s;
    o.seg = c;
    probe_q.push_back(o);
  endtask

  // Returns on the falling edge of the dark cycle that opens a new frame.
  task automatic wait_frames(input int n);
    logic [5:0] p;
    int         budget;
    bit         hit;
    for (int k = 0; k < n; k++) begin
      p      = '0;
      budget = 0;
      hit    = 1'b0;
      while (!hit && budget < 100) begin
        @(negedge sys_clk);
        budget++;
        if (p == 6'b100000 && sel == 6'b000000) hit = 1'b1;
        p = sel;
      end
      if (!hit) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s/frame_sync: got no frame boundary in %0d cycles, expected one within 100",
                 tname, budget);
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || probe_q.size() > 0) && t < 400) begin
      @(negedge sys_clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s/drain: got %0d expectations unmatched, expected 0",
               tname, exp_q.size() + probe_q.size());
      exp_q.delete();
      probe_q.delete();
    end
  endtask

  task automatic set_inputs(input logic [DATA_W-1:0] d, input logic s,
                            input logic [DIGITS-1:0] p);
    @(posedge sys_clk);
    #1;
    data  = d;
    sign  = s;
    point = p;
  endtask

  initial begin : stimulus
    // Reset state
    #1 sys_rst = 1'b1;
    #1 push_probe(6'b000000, 8'hFF);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    drain();

    // 9876 with sign and dp on digit 1
    tname = "neg9876";
    set_inputs(20'd9876, 1'b1, 6'b000010);
    wait_frames(3);
    push_frame({8'hFF, 8'hBF, 8'h90, 8'h80, 8'h78, 8'h82});
    drain();

    // Zero shows a single 0
    tname = "zero";
    set_inputs(20'd0, 1'b0, 6'b000000);
    wait_frames(3);
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
    drain();

    // Sign right next to a short value, dp on digit 0
    tname = "neg42";
    set_inputs(20'd42, 1'b1, 6'b000001);
    wait_frames(3);
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'h24});
    drain();

    // Six digits plus sign overflow; dp suppressed
    tname = "ovf_sign";
    set_inputs(20'd999999, 1'b1, 6'b000100);
    wait_frames(3);
    push_frame({8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});
    drain();

    // Seven-digit value overflows without sign
    tname = "ovf_wide";
    set_inputs(20'd1048575, 1'b0, 6'b000000);
    wait_frames(3);
    push_frame({8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});
    drain();

    // seg_en dropped while digit 2 is lit, restored during digit 4's slot
    tname = "seg_en";
    set_inputs(20'd9876, 1'b1, 6'b000010);
    wait_frames(3);
    repeat (12) @(posedge sys_clk);
    #1 seg_en = 1'b0;
    @(posedge sys_clk);
    #1 push_probe(6'b000000, 8'hFF);
    repeat (8) @(posedge sys_clk);
    #1 push_probe(6'b000000, 8'hFF);
    repeat (2) @(posedge sys_clk);
    #1 seg_en = 1'b1;
    push_slot(6'b010000, 8'hBF);
    push_slot(6'b100000, 8'hFF);
    drain();

    // Blink from a known phase: frames 2,3 off and 4,5 on after reset
    tname = "blink";
    set_inputs(20'd5, 1'b0, 6'b000000);
    blink = 6'b000001;
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wait_frames(2);
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF});
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92});
    push_frame({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92});
    drain();
    blink = 6'b000000;

    // Reset pulsed while the converter is mid-way through a new value
    tname = "rst_mid";
    set_inputs(20'd123456, 1'b0, 6'b000000);
    wait_frames(1);
    repeat (7) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    push_probe(6'b000000, 8'hFF);
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    wait_frames(2);
    push_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    drain();

    repeat (2) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no completion by 300000 time units, expected completion");
    $fatal(1);
  end

endmodule
